// File: rtl/lcd_rect_fill.sv
// Rectangle-fill engine for an ST7789-class SPI TFT panel: programs the CASET/RASET window,
// issues RAMWR and streams a constant colour through the {dc,byte} writer handshake.
module lcd_rect_fill #(
  parameter int unsigned H_RES    = 240,
  parameter int unsigned V_RES    = 320,
  parameter int unsigned COORD_W  = 9,
  parameter int unsigned PIX_MODE = 0,
  parameter int unsigned CNT_W    = 17
) (
  input  logic               sys_clk_50MHz,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [23:0]        color,
  output logic [8:0]         wr_data,
  output logic               wr_en,
  input  logic               wr_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned Bpp = (PIX_MODE == 1) ? 3 : 2;

  typedef enum logic [2:0] {StIdle, StCalc, StSetup, StPixel, StFinish} state_e;

  state_e             state_q, state_d;
  logic [3:0]         sidx_q, sidx_d;
  logic [1:0]         bidx_q, bidx_d;
  logic [CNT_W-1:0]   npix_q, npix_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic               accept;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [23:0]        color_q;

  logic               start_ok;
  logic [COORD_W:0]   win_w, win_h;
  logic [2*COORD_W+1:0] area;
  logic [15:0]        x0_16, x1_16, y0_16, y1_16;

  assign start_ok = (x1 >= x0) && (y1 >= y0) && (32'(x1) < H_RES) && (32'(y1) < V_RES);

  assign win_w = {1'b0, x1_q} - {1'b0, x0_q} + {{COORD_W{1'b0}}, 1'b1};
  assign win_h = {1'b0, y1_q} - {1'b0, y0_q} + {{COORD_W{1'b0}}, 1'b1};
  assign area  = win_w * win_h;

  assign x0_16 = 16'(x0_q);
  assign x1_16 = 16'(x1_q);
  assign y0_16 = 16'(y0_q);
  assign y1_16 = 16'(y1_q);

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q <= StIdle;
      sidx_q  <= '0;
      bidx_q  <= '0;
      npix_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
      bidx_q  <= bidx_d;
      npix_q  <= npix_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      if (accept) begin
        x0_q    <= x0;
        y0_q    <= y0;
        x1_q    <= x1;
        y1_q    <= y1;
        color_q <= color;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    bidx_d  = bidx_q;
    npix_d  = npix_q;
    abort_d = abort_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (start) begin
          if (start_ok) begin
            accept  = 1'b1;
            state_d = StCalc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCalc: begin
        npix_d  = CNT_W'(area);
        sidx_d  = '0;
        bidx_d  = '0;
        state_d = StSetup;
        if (abort) abort_d = 1'b1;
      end
      StSetup: begin
        if (abort) abort_d = 1'b1;
        if (wr_done) begin
          // A byte completing together with abort still counts as sent.
          if (abort_q || abort) begin
            state_d = StFinish;
          end else if (sidx_q == 4'd10) begin
            bidx_d  = '0;
            state_d = StPixel;
          end else begin
            sidx_d = sidx_q + 4'd1;
          end
        end
      end
      StPixel: begin
        if (abort) abort_d = 1'b1;
        if (wr_done) begin
          if (abort_q || abort) begin
            state_d = StFinish;
          end else if (bidx_q == 2'(Bpp - 1)) begin
            bidx_d = '0;
            if (npix_q <= CNT_W'(1)) begin
              npix_d  = '0;
              state_d = StFinish;
            end else begin
              npix_d = npix_q - CNT_W'(1);
            end
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end
      end
      StFinish: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_data = 9'h000;
    wr_en   = (state_q == StSetup) || (state_q == StPixel);
    busy    = (state_q == StCalc) || wr_en;
    done    = (state_q == StFinish);
    err     = err_q;
    if (state_q == StSetup) begin
      case (sidx_q)
        4'd0:    wr_data = {1'b0, 8'h2A};
        4'd1:    wr_data = {1'b1, x0_16[15:8]};
        4'd2:    wr_data = {1'b1, x0_16[7:0]};
        4'd3:    wr_data = {1'b1, x1_16[15:8]};
        4'd4:    wr_data = {1'b1, x1_16[7:0]};
        4'd5:    wr_data = {1'b0, 8'h2B};
        4'd6:    wr_data = {1'b1, y0_16[15:8]};
        4'd7:    wr_data = {1'b1, y0_16[7:0]};
        4'd8:    wr_data = {1'b1, y1_16[15:8]};
        4'd9:    wr_data = {1'b1, y1_16[7:0]};
        default: wr_data = {1'b0, 8'h2C};
      endcase
    end else if (state_q == StPixel) begin
      if (PIX_MODE == 1) begin
        case (bidx_q)
          2'd0:    wr_data = {1'b1, color_q[23:16]};
          2'd1:    wr_data = {1'b1, color_q[15:8]};
          default: wr_data = {1'b1, color_q[7:0]};
        endcase
      end else begin
        wr_data = (bidx_q == 2'd0) ? {1'b1, color_q[15:8]} : {1'b1, color_q[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_lcd_rect_fill.sv
// Directed bench for lcd_rect_fill: RGB565 and RGB666 instances at panel size plus a small
// 16x12 instance so a complete full-screen fill fits in a short run.
module tb_lcd_rect_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort, start_r, wd_r;
  logic [8:0] x0, y0, x1, y1;
  logic [23:0] color;
  int         sel;
  int         passed = 0;
  int         total  = 0;
  int         done_cnt = 0;

  logic       st0, st1, st2, wd0, wd1, wd2;
  logic [8:0] wdat0, wdat1, wdat2;
  logic       we0, we1, we2, bz0, bz1, bz2, dn0, dn1, dn2, er0, er1, er2;
  logic [8:0] cur_wr_data;
  logic       cur_wr_en, cur_busy, cur_done, cur_err;

  assign st0 = start_r && (sel == 0);
  assign st1 = start_r && (sel == 1);
  assign st2 = start_r && (sel == 2);
  assign wd0 = wd_r && (sel == 0);
  assign wd1 = wd_r && (sel == 1);
  assign wd2 = wd_r && (sel == 2);

  lcd_rect_fill #(.PIX_MODE(0)) dut565 (
    .sys_clk_50MHz(clk), .sys_rst(rst), .start(st0), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .wr_data(wdat0), .wr_en(we0), .wr_done(wd0), .busy(bz0), .done(dn0), .err(er0)
  );

  lcd_rect_fill #(.PIX_MODE(1)) dut666 (
    .sys_clk_50MHz(clk), .sys_rst(rst), .start(st1), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .wr_data(wdat1), .wr_en(we1), .wr_done(wd1), .busy(bz1), .done(dn1), .err(er1)
  );

  lcd_rect_fill #(.H_RES(16), .V_RES(12), .PIX_MODE(0)) dut_small (
    .sys_clk_50MHz(clk), .sys_rst(rst), .start(st2), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .wr_data(wdat2), .wr_en(we2), .wr_done(wd2), .busy(bz2), .done(dn2), .err(er2)
  );

  always_comb begin
    cur_wr_data = wdat0;
    cur_wr_en   = we0;
    cur_busy    = bz0;
    cur_done    = dn0;
    cur_err     = er0;
    if (sel == 1) begin
      cur_wr_data = wdat1; cur_wr_en = we1; cur_busy = bz1; cur_done = dn1; cur_err = er1;
    end else if (sel == 2) begin
      cur_wr_data = wdat2; cur_wr_en = we2; cur_busy = bz2; cur_done = dn2; cur_err = er2;
    end
  end

  always @(negedge clk) if (cur_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-writer model: wait for a request, take the byte and pulse wr_done for one cycle.
  task automatic get_byte(input bit with_abort, output logic [8:0] b);
    int n = 0;
    while (cur_wr_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("byte_ready", {31'b0, cur_wr_en}, 32'd1);
    b     = cur_wr_data;
    wd_r  = 1'b1;
    abort = with_abort;
    tick();
    wd_r  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic expect_setup(input string tag, input logic [8:0] e [11]);
    logic [8:0] b;
    for (int i = 0; i < 11; i++) begin
      get_byte(1'b0, b);
      chk(tag, {23'b0, b}, {23'b0, e[i]});
    end
  endtask

  task automatic set_win(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                         input logic [8:0] d);
    x0 = a; x1 = b; y0 = c; y1 = d;
  endtask

  task automatic pulse_start();
    start_r = 1'b1;
    tick();
    start_r = 1'b0;
  endtask

  logic [8:0] b;
  logic [8:0] exp11 [11];
  int         base, bad;

  initial begin
    rst = 1'b1; abort = 1'b0; start_r = 1'b0; wd_r = 1'b0; sel = 0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;

    // Reset then idle
    for (int i = 0; i < 3; i++) tick();
    chk("rst_wr_data", {23'b0, cur_wr_data}, 32'h0);
    chk("rst_wr_en", {31'b0, cur_wr_en}, 32'd0);
    chk("rst_busy", {31'b0, cur_busy}, 32'd0);
    chk("rst_done", {31'b0, cur_done}, 32'd0);
    chk("rst_err", {31'b0, cur_err}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_wr_en", {31'b0, cur_wr_en}, 32'd0);
      chk("idle_busy", {31'b0, cur_busy}, 32'd0);
      chk("idle_wr_data", {23'b0, cur_wr_data}, 32'h0);
    end

    // Invalid windows: x1<x0, then y1==V_RES
    set_win(9'd5, 9'd4, 9'd0, 9'd10);
    pulse_start();
    chk("badx_err", {31'b0, cur_err}, 32'd1);
    chk("badx_busy", {31'b0, cur_busy}, 32'd0);
    tick();
    chk("badx_err_pulse", {31'b0, cur_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("badx_wr_en", {31'b0, cur_wr_en}, 32'd0);
      tick();
    end
    set_win(9'd0, 9'd1, 9'd0, 9'd320);
    pulse_start();
    chk("bady_err", {31'b0, cur_err}, 32'd1);
    chk("bady_busy", {31'b0, cur_busy}, 32'd0);
    tick();
    chk("bady_err_pulse", {31'b0, cur_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bady_wr_en", {31'b0, cur_wr_en}, 32'd0);
      tick();
    end

    // Full-screen RGB565 at 240x320: setup, first pixels, inputs changed mid-job
    set_win(9'd0, 9'd239, 9'd0, 9'd319);
    color = 24'h00F800;
    pulse_start();
    chk("fs_calc_busy", {31'b0, cur_busy}, 32'd1);
    chk("fs_calc_wr_en", {31'b0, cur_wr_en}, 32'd0);
    color = 24'h000000;
    set_win(9'd7, 9'd8, 9'd9, 9'd10);
    exp11 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B,
              9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
    expect_setup("fs_setup", exp11);
    for (int i = 0; i < 3; i++) begin
      get_byte(1'b0, b);
      chk("fs_pix_hi", {23'b0, b}, 32'h1F8);
      get_byte(1'b0, b);
      chk("fs_pix_lo", {23'b0, b}, 32'h100);
    end
    get_byte(1'b1, b);
    chk("fs_abort_byte", {23'b0, b}, 32'h1F8);
    chk("fs_abort_done", {31'b0, cur_done}, 32'd1);
    chk("fs_abort_wr_en", {31'b0, cur_wr_en}, 32'd0);
    tick();
    chk("fs_abort_idle", {30'b0, cur_busy, cur_done}, 32'd0);

    // Complete full-screen fill on the 16x12 instance
    sel = 2;
    set_win(9'd0, 9'd15, 9'd0, 9'd11);
    color = 24'h0007E0;
    base = done_cnt;
    pulse_start();
    exp11 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h10F, 9'h02B,
              9'h100, 9'h100, 9'h100, 9'h10B, 9'h02C};
    expect_setup("sm_setup", exp11);
    bad = 0;
    for (int i = 0; i < 192; i++) begin
      get_byte(1'b0, b);
      if (b !== 9'h107) bad++;
      get_byte(1'b0, b);
      if (b !== 9'h1E0) bad++;
    end
    chk("sm_pix_bad", bad, 32'd0);
    chk("sm_done", {31'b0, cur_done}, 32'd1);
    chk("sm_busy_low", {31'b0, cur_busy}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("sm_no_extra", {31'b0, cur_wr_en}, 32'd0);
    chk("sm_done_once", done_cnt - base, 32'd1);

    // Single pixel RGB666
    sel = 1;
    set_win(9'd10, 9'd10, 9'd20, 9'd20);
    color = 24'h12FC40;
    pulse_start();
    exp11 = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10A, 9'h02B,
              9'h100, 9'h114, 9'h100, 9'h114, 9'h02C};
    expect_setup("sp_setup", exp11);
    get_byte(1'b0, b);
    chk("sp_r", {23'b0, b}, 32'h112);
    get_byte(1'b0, b);
    chk("sp_g", {23'b0, b}, 32'h1FC);
    get_byte(1'b0, b);
    chk("sp_b", {23'b0, b}, 32'h140);
    chk("sp_done", {31'b0, cur_done}, 32'd1);
    chk("sp_busy", {31'b0, cur_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sp_no_extra", {31'b0, cur_wr_en}, 32'd0);
    end

    // Abort on the 20th wr_done of a 4x4 RGB565 fill
    sel = 0;
    set_win(9'd0, 9'd3, 9'd0, 9'd3);
    color = 24'h00F800;
    pulse_start();
    exp11 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02B,
              9'h100, 9'h100, 9'h100, 9'h103, 9'h02C};
    expect_setup("ab_setup", exp11);
    for (int i = 0; i < 8; i++) begin
      get_byte(1'b0, b);
      chk("ab_pix", {23'b0, b}, (i % 2 == 0) ? 32'h1F8 : 32'h100);
    end
    get_byte(1'b1, b);
    chk("ab_byte20", {23'b0, b}, 32'h1F8);
    chk("ab_done", {31'b0, cur_done}, 32'd1);
    chk("ab_wr_en", {31'b0, cur_wr_en}, 32'd0);
    // Start in the FINISH cycle is ignored: invalid window would otherwise raise err
    set_win(9'd5, 9'd4, 9'd0, 9'd0);
    start_r = 1'b1;
    tick();
    chk("fin_start_err", {31'b0, cur_err}, 32'd0);
    chk("fin_start_busy", {31'b0, cur_busy}, 32'd0);
    set_win(9'd2, 9'd5, 9'd1, 9'd2);
    tick();
    start_r = 1'b0;
    chk("ab_restart_busy", {31'b0, cur_busy}, 32'd1);

    // Start while busy ignored, then reset during PIXEL
    exp11 = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h105, 9'h02B,
              9'h100, 9'h101, 9'h100, 9'h102, 9'h02C};
    for (int i = 0; i < 3; i++) begin
      get_byte(1'b0, b);
      chk("sb_setup", {23'b0, b}, {23'b0, exp11[i]});
    end
    set_win(9'd0, 9'd0, 9'd0, 9'd0);
    color = 24'h000000;
    pulse_start();
    chk("sb_err", {31'b0, cur_err}, 32'd0);
    chk("sb_busy", {31'b0, cur_busy}, 32'd1);
    for (int i = 3; i < 11; i++) begin
      get_byte(1'b0, b);
      chk("sb_setup", {23'b0, b}, {23'b0, exp11[i]});
    end
    get_byte(1'b0, b);
    chk("sb_pix_hi", {23'b0, b}, 32'h1F8);
    get_byte(1'b0, b);
    chk("sb_pix_lo", {23'b0, b}, 32'h100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_wr_en", {31'b0, cur_wr_en}, 32'd0);
    chk("mr_busy", {31'b0, cur_busy}, 32'd0);
    set_win(9'd1, 9'd1, 9'd2, 9'd2);
    color = 24'h00ABCD;
    pulse_start();
    exp11 = '{9'h02A, 9'h100, 9'h101, 9'h100, 9'h101, 9'h02B,
              9'h100, 9'h102, 9'h100, 9'h102, 9'h02C};
    expect_setup("mr_setup", exp11);
    get_byte(1'b0, b);
    chk("mr_pix_hi", {23'b0, b}, 32'h1AB);
    get_byte(1'b0, b);
    chk("mr_pix_lo", {23'b0, b}, 32'h1CD);
    chk("mr_done", {31'b0, cur_done}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
